dmem_store_buffer: RTL

Posted-write store buffer between the core's MEM-stage data port and the single-port data memory (sync write, combinational read).
- Stores are queued and retire to memory whenever the memory port is not needed by a load.
- Loads are checked against pending stores; RAW hazards stall, or forward when the forwarding option is compiled in.
- Adds a fence input for ordering at program end and before memory dumps.

---
 rtl/dmem_store_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dmem_store_buffer
// Purpose  : Posted-write store buffer in front of a single-port data memory.
//            Optional macro STB_FWD_EN forwards pending store data to loads.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_wen,
    input  logic                       cpu_ren,
    input  logic [ADDR_W-1:0]          cpu_addr,
    input  logic [DATA_W-1:0]          cpu_wdata,
    input  logic                       fence_req,
    output logic [DATA_W-1:0]          cpu_rdata,
    output logic                       cpu_stall,
    output logic                       mem_wen,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               w_rd;
    logic               w_hit;
    logic               w_raw;
    logic               w_full;
    logic               w_nonempty;
    logic               w_stall;
    logic               w_port_load;
    logic               w_push;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_idx;
`ifdef STB_FWD_EN
    logic [DATA_W-1:0]  w_fwd_data;
`endif

    // Walk pending entries oldest to youngest so the last match is the youngest.
    always_comb begin
        w_hit = 1'b0;
        w_idx = r_head;
`ifdef STB_FWD_EN
        w_fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + c_PTR_W'(k);
            if ((c_CNT_W'(k) < r_count) &&
                (r_addr[w_idx][ADDR_W-1:2] == cpu_addr[ADDR_W-1:2])) begin
                w_hit = 1'b1;
`ifdef STB_FWD_EN
                w_fwd_data = r_data[w_idx];
`endif
            end
        end
    end

    assign w_rd       = cpu_ren & ~cpu_wen;
    assign w_full     = (r_count == c_CNT_W'(DEPTH));
    assign w_nonempty = (r_count != '0);

`ifdef STB_FWD_EN
    assign w_raw       = 1'b0;
    assign w_port_load = ~rst & w_rd & ~w_stall & ~w_hit;
    assign cpu_rdata   = w_hit ? w_fwd_data : mem_rdata;
`else
    assign w_raw       = w_rd & w_hit;
    assign w_port_load = ~rst & w_rd & ~w_stall;
    assign cpu_rdata   = mem_rdata;
`endif

    assign w_stall = ~rst & ((cpu_wen & w_full) | w_raw | (fence_req & w_nonempty));
    assign w_push  = ~rst & cpu_wen & ~w_stall;
    // The head retires whenever a load is not using the memory port.
    assign w_pop   = ~rst & ~w_port_load & w_nonempty;

    assign cpu_stall = w_stall;
    assign mem_wen   = w_pop;
    assign mem_addr  = w_pop ? r_addr[r_head] : cpu_addr;
    assign mem_wdata = r_data[r_head];
    assign empty     = rst | ~w_nonempty;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= cpu_addr;
            r_data[r_tail] <= cpu_wdata;
        end
    end

endmodule
`default_nettype wire
